// File: rtl/rom_word_unpacker.sv
// Buffers 32-bit bridge word writes in a small FIFO and replays each word as
// four paced, big-endian byte writes on the core's ioctl ROM load port.
module rom_word_unpacker #(
    parameter int ADDR_WIDTH = 25,
    parameter int CYCLES     = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_wr,
    input  logic [31:0]           in_addr,
    input  logic [31:0]           in_data,
    output logic                  ioctl_wr,
    output logic [ADDR_WIDTH-1:0] ioctl_addr,
    output logic [7:0]            ioctl_data,
    output logic                  busy,
    output logic                  overflow
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int BASE_W  = ADDR_WIDTH - 2;
    localparam int ENTRY_W = BASE_W + 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_WAIT
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [ENTRY_W-1:0]       mem_q [DEPTH];
    logic [ENTRY_W-1:0]       mem_d [DEPTH];
    logic [BASE_W-1:0]        base_q, base_d;
    logic [31:0]              word_q, word_d;
    logic [1:0]               k_q, k_d;
    logic [7:0]               gap_q, gap_d;
    logic                     ioctl_wr_q, ioctl_wr_d;
    logic [ADDR_WIDTH-1:0]    ioctl_addr_q, ioctl_addr_d;
    logic [7:0]               ioctl_data_q, ioctl_data_d;
    logic                     overflow_q, overflow_d;

    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     push;
    logic                     pop;
    logic [ENTRY_W-1:0]       head;
    logic [7:0]               cur_byte;

    // Address bits above the core's range and the in-word offset are not used.
    generate
        if (ADDR_WIDTH < 32) begin : g_unused_hi
            logic unused_addr_bits;
            assign unused_addr_bits = ^{in_addr[31:ADDR_WIDTH], in_addr[1:0]};
        end else begin : g_unused_lo
            logic unused_addr_bits;
            assign unused_addr_bits = ^in_addr[1:0];
        end
    endgenerate

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign head       = mem_q[rd_ptr_q];

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push = in_wr && (!fifo_full || pop);

    always_comb begin
        cur_byte = word_q[7:0];
        case (k_q)
            2'd0:    cur_byte = word_q[31:24];
            2'd1:    cur_byte = word_q[23:16];
            2'd2:    cur_byte = word_q[15:8];
            default: cur_byte = word_q[7:0];
        endcase
    end

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        gap_d        = gap_q;
        base_d       = base_q;
        word_d       = word_q;
        pop          = 1'b0;
        ioctl_wr_d   = 1'b0;
        ioctl_addr_d = ioctl_addr_q;
        ioctl_data_d = ioctl_data_q;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    base_d  = head[ENTRY_W-1:32];
                    word_d  = head[31:0];
                    k_d     = 2'd0;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                ioctl_wr_d   = 1'b1;
                ioctl_addr_d = {base_q, k_q};
                ioctl_data_d = cur_byte;
                gap_d        = 8'(CYCLES - 1);
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                gap_d = gap_q - 8'd1;
                if (gap_q == 8'd1) begin
                    if (k_q != 2'd3) begin
                        k_d     = k_q + 2'd1;
                        state_d = S_EMIT;
                    end else if (!fifo_empty) begin
                        pop     = 1'b1;
                        base_d  = head[ENTRY_W-1:32];
                        word_d  = head[31:0];
                        k_d     = 2'd0;
                        state_d = S_EMIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (in_wr & ~push);
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end

        if (push) begin
            mem_d[wr_ptr_q] = {in_addr[ADDR_WIDTH-1:2], in_data};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            base_q       <= '0;
            word_q       <= '0;
            k_q          <= 2'd0;
            gap_q        <= 8'd0;
            ioctl_wr_q   <= 1'b0;
            ioctl_addr_q <= '0;
            ioctl_data_q <= 8'd0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            base_q       <= base_d;
            word_q       <= word_d;
            k_q          <= k_d;
            gap_q        <= gap_d;
            ioctl_wr_q   <= ioctl_wr_d;
            ioctl_addr_q <= ioctl_addr_d;
            ioctl_data_q <= ioctl_data_d;
            overflow_q   <= overflow_d;
        end
    end

    // Storage is only ever read through valid pointers, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign ioctl_wr   = ioctl_wr_q;
    assign ioctl_addr = ioctl_addr_q;
    assign ioctl_data = ioctl_data_q;
    assign overflow   = overflow_q;
    assign busy       = !fifo_empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_rom_word_unpacker.sv
// Directed bench for rom_word_unpacker: table of single-word vectors plus
// hand-written back-to-back, overflow, push-while-full and reset sequences.
module tb_rom_word_unpacker;

    localparam int AW  = 25;
    localparam int CYC = 8;
    localparam int DEP = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_wr = 1'b0;
    logic [31:0]   in_addr = '0;
    logic [31:0]   in_data = '0;
    logic          ioctl_wr;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_data;
    logic          busy;
    logic          overflow;

    rom_word_unpacker #(
        .ADDR_WIDTH(AW),
        .CYCLES    (CYC),
        .DEPTH     (DEP)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_wr     (in_wr),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .ioctl_wr  (ioctl_wr),
        .ioctl_addr(ioctl_addr),
        .ioctl_data(ioctl_data),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            e;
        logic [AW-1:0] a;
        logic [7:0]    d;
    } strobe_t;

    typedef struct {
        logic [31:0]     addr;
        logic [31:0]     data;
        logic [AW-1:0]   exp_base;
        logic [0:3][7:0] exp_d;
    } vec_t;

    int      cyc = 0;
    int      total = 0;
    int      bad = 0;
    strobe_t sq[$];
    strobe_t ex[$];
    vec_t    vecs[4];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ioctl_wr) sq.push_back('{cyc - 1, ioctl_addr, ioctl_data});
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        sq.delete();
        ex.delete();
        @(negedge clk);
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d, output int t);
        in_wr   = 1'b1;
        in_addr = a;
        in_data = d;
        @(posedge clk);
        t = cyc;
        #1;
        in_wr = 1'b0;
    endtask

    task automatic expect_word(input int first_e, input logic [AW-1:0] base,
                               input logic [0:3][7:0] bytes);
        for (int i = 0; i < 4; i++) begin
            ex.push_back('{first_e + CYC * i, base + AW'(i), bytes[i]});
        end
    endtask

    task automatic wait_idle(input string nm, input int lim);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < lim);
        chk({nm, "_idle"}, 64'(busy), 64'(0));
    endtask

    task automatic compare_strobes(input string nm);
        int n;
        chk({nm, "_count"}, 64'(sq.size()), 64'(ex.size()));
        n = (sq.size() < ex.size()) ? sq.size() : ex.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_edge%0d", nm, i), 64'(sq[i].e), 64'(ex[i].e));
            chk($sformatf("%s_addr%0d", nm, i), 64'(sq[i].a), 64'(ex[i].a));
            chk($sformatf("%s_data%0d", nm, i), 64'(sq[i].d), 64'(ex[i].d));
        end
    endtask

    initial begin
        int t;
        int t0;
        int e;

        vecs[0] = '{32'h0000_1004, 32'hA1B2_C3D4, 25'h000_1004, {8'hA1, 8'hB2, 8'hC3, 8'hD4}};
        vecs[1] = '{32'h01FF_FFFE, 32'hDEAD_BEEF, 25'h1FF_FFFC, {8'hDE, 8'hAD, 8'hBE, 8'hEF}};
        vecs[2] = '{32'h0000_0003, 32'h0F1E_2D3C, 25'h000_0000, {8'h0F, 8'h1E, 8'h2D, 8'h3C}};
        vecs[3] = '{32'hFE00_0010, 32'h89AB_CDEF, 25'h000_0010, {8'h89, 8'hAB, 8'hCD, 8'hEF}};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ioctl_wr", 64'(ioctl_wr), 64'(0));
        chk("rst_ioctl_addr", 64'(ioctl_addr), 64'(0));
        chk("rst_ioctl_data", 64'(ioctl_data), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));

        // Single-word vectors: latency, pacing, byte order, busy window
        for (int v = 0; v < 4; v++) begin
            do_reset();
            write_word(vecs[v].addr, vecs[v].data, t);
            expect_word(t + 2, vecs[v].exp_base, vecs[v].exp_d);
            for (int j = 0; j <= 40; j++) begin
                @(negedge clk);
                e = cyc - 1;
                if (e == t)      chk($sformatf("v%0d_busy_rise", v), 64'(busy), 64'(1));
                if (e == t + 32) chk($sformatf("v%0d_busy_last", v), 64'(busy), 64'(1));
                if (e == t + 33) chk($sformatf("v%0d_busy_fall", v), 64'(busy), 64'(0));
            end
            compare_strobes($sformatf("vec%0d", v));
        end

        // Back-to-back words one cycle apart
        do_reset();
        write_word(32'h0, 32'h1122_3344, t0);
        write_word(32'h4, 32'h5566_7788, t);
        chk("b2b_adjacent", 64'(t - t0), 64'(1));
        expect_word(t0 + 2, 25'h0, {8'h11, 8'h22, 8'h33, 8'h44});
        expect_word(t0 + 2 + 4 * CYC, 25'h4, {8'h55, 8'h66, 8'h77, 8'h88});
        wait_idle("b2b", 200);
        compare_strobes("b2b");

        // Six consecutive writes: five kept, sixth dropped, overflow sticky
        do_reset();
        for (int i = 0; i < 6; i++) begin
            write_word(32'h100 * i, {4{8'(8'h10 * i + 1)}}, t);
            if (i == 0) t0 = t;
            if (i == 4) chk("ovf_before", 64'(overflow), 64'(0));
            if (i == 5) chk("ovf_set", 64'(overflow), 64'(1));
        end
        for (int i = 0; i < 5; i++) begin
            expect_word(t0 + 2 + 4 * CYC * i, AW'(32'h100 * i), {4{8'(8'h10 * i + 1)}});
        end
        wait_idle("ovf", 400);
        compare_strobes("ovf");
        chk("ovf_sticky", 64'(overflow), 64'(1));

        // Write landing on the pop edge while the FIFO is full
        do_reset();
        for (int i = 0; i < 5; i++) begin
            write_word(32'h40 * i, {4{8'(8'h21 + i)}}, t);
            if (i == 0) t0 = t;
        end
        while (cyc != t0 + 4 * CYC + 1) @(negedge clk);
        write_word(32'h200, 32'hCAFE_F00D, t);
        chk("pwf_edge", 64'(t), 64'(t0 + 4 * CYC + 1));
        chk("pwf_no_ovf_now", 64'(overflow), 64'(0));
        for (int i = 0; i < 5; i++) begin
            expect_word(t0 + 2 + 4 * CYC * i, AW'(32'h40 * i), {4{8'(8'h21 + i)}});
        end
        expect_word(t0 + 2 + 4 * CYC * 5, 25'h200, {8'hCA, 8'hFE, 8'hF0, 8'h0D});
        wait_idle("pwf", 500);
        compare_strobes("pwf");
        chk("pwf_no_ovf", 64'(overflow), 64'(0));

        // Reset between the 2nd and 3rd byte strobes
        do_reset();
        write_word(32'h0000_0800, 32'h0102_0304, t0);
        write_word(32'h0000_0804, 32'h0506_0708, t);
        while (cyc != t0 + 2 + CYC + 3) @(negedge clk);
        chk("mid_two_strobes", 64'(sq.size()), 64'(2));
        reset_n = 1'b0;
        #1;
        chk("mid_ioctl_wr", 64'(ioctl_wr), 64'(0));
        chk("mid_busy", 64'(busy), 64'(0));
        chk("mid_addr", 64'(ioctl_addr), 64'(0));
        chk("mid_data", 64'(ioctl_data), 64'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        sq.delete();
        repeat (60) @(negedge clk);
        chk("mid_no_strobes", 64'(sq.size()), 64'(0));
        chk("mid_busy_after", 64'(busy), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
